// File: rtl/xadac_vload_if.sv
// Handshake bundle of the XADAC vector load unit: decode, execute and the AXI read channels.
// The slave view belongs to the load unit; the master view is the core/memory side.
interface xadac_vload_if #(
    parameter int unsigned SbLen        = 4,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned VecDataWidth = 128,
    parameter int unsigned RegDataWidth = 32
);
    localparam int unsigned IdWidth = $clog2(SbLen);

    logic                    dec_req_valid;
    logic                    dec_req_ready;
    logic [IdWidth-1:0]      dec_req_id;
    logic                    dec_rsp_valid;
    logic                    dec_rsp_ready;
    logic [IdWidth-1:0]      dec_rsp_id;
    logic                    dec_rsp_accept;
    logic [1:0]              dec_rsp_rs_read;
    logic [1:0]              dec_rsp_vs_read;
    logic                    dec_rsp_vd_clobber;
    logic                    dec_rsp_rd_clobber;

    logic                    exe_req_valid;
    logic                    exe_req_ready;
    logic [IdWidth-1:0]      exe_req_id;
    logic [31:0]             exe_req_instr;
    logic [RegDataWidth-1:0] exe_req_rs0;
    logic                    exe_rsp_valid;
    logic                    exe_rsp_ready;
    logic [IdWidth-1:0]      exe_rsp_id;
    logic [VecDataWidth-1:0] exe_rsp_vd_data;
    logic                    exe_rsp_err;

    logic [IdWidth-1:0]      axi_ar_id;
    logic [AddrWidth-1:0]    axi_ar_addr;
    logic                    axi_ar_valid;
    logic                    axi_ar_ready;
    logic [IdWidth-1:0]      axi_r_id;
    logic [VecDataWidth-1:0] axi_r_data;
    logic [1:0]              axi_r_resp;
    logic                    axi_r_valid;
    logic                    axi_r_ready;

    modport slave (
        input  dec_req_valid, dec_req_id, dec_rsp_ready,
        output dec_req_ready, dec_rsp_valid, dec_rsp_id, dec_rsp_accept,
        output dec_rsp_rs_read, dec_rsp_vs_read, dec_rsp_vd_clobber, dec_rsp_rd_clobber,
        input  exe_req_valid, exe_req_id, exe_req_instr, exe_req_rs0, exe_rsp_ready,
        output exe_req_ready, exe_rsp_valid, exe_rsp_id, exe_rsp_vd_data, exe_rsp_err,
        output axi_ar_id, axi_ar_addr, axi_ar_valid, axi_r_ready,
        input  axi_ar_ready, axi_r_id, axi_r_data, axi_r_resp, axi_r_valid
    );

    modport master (
        output dec_req_valid, dec_req_id, dec_rsp_ready,
        input  dec_req_ready, dec_rsp_valid, dec_rsp_id, dec_rsp_accept,
        input  dec_rsp_rs_read, dec_rsp_vs_read, dec_rsp_vd_clobber, dec_rsp_rd_clobber,
        output exe_req_valid, exe_req_id, exe_req_instr, exe_req_rs0, exe_rsp_ready,
        input  exe_req_ready, exe_rsp_valid, exe_rsp_id, exe_rsp_vd_data, exe_rsp_err,
        input  axi_ar_id, axi_ar_addr, axi_ar_valid, axi_r_ready,
        output axi_ar_ready, axi_r_id, axi_r_data, axi_r_resp, axi_r_valid
    );
endinterface

// File: rtl/xadac_vload.sv
// XADAC vector load unit: per-ID scoreboard that issues one AXI read per load instruction
// and returns the length-masked vector through the execute response.
module xadac_vload #(
    parameter int unsigned SbLen        = 4,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned VecDataWidth = 128,
    parameter int unsigned VecLenWidth  = 5,
    parameter int unsigned RegDataWidth = 32
) (
    input  logic         clk,
    input  logic         rstn,
    xadac_vload_if.slave io
);
    localparam int unsigned IdWidth  = $clog2(SbLen);
    localparam int unsigned NumBytes = VecDataWidth / 8;

    typedef struct packed {
        logic [AddrWidth-1:0]    addr;
        logic [VecLenWidth-1:0]  vlen;
        logic [VecDataWidth-1:0] data;
        logic                    err;
        logic                    req_done;
        logic                    ar_done;
        logic                    r_done;
        logic                    rsp_done;
    } sb_entry_t;

    sb_entry_t sb_q [SbLen];
    sb_entry_t sb_d [SbLen];

    logic                    ar_valid_q,  ar_valid_d;
    logic [IdWidth-1:0]      ar_id_q,     ar_id_d;
    logic [AddrWidth-1:0]    ar_addr_q,   ar_addr_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [IdWidth-1:0]      rsp_id_q,    rsp_id_d;
    logic [VecDataWidth-1:0] rsp_data_q,  rsp_data_d;
    logic                    rsp_err_q,   rsp_err_d;
    logic                    r_ready_q;
    logic                    ar_pick;
    logic                    rsp_pick;

    logic                    exe_req_ready_c;
    logic [RegDataWidth-1:0] rs0_c;
    logic [AddrWidth-1:0]    base_addr_c;
    logic [VecLenWidth-1:0]  vlen_raw_c;
    logic [VecLenWidth-1:0]  vlen_c;
    logic                    unused_bits;

    // Zero every byte at or above the element count.
    function automatic logic [VecDataWidth-1:0] mask_bytes(input logic [VecDataWidth-1:0] d,
                                                           input logic [VecLenWidth-1:0]  vlen);
        logic [VecDataWidth-1:0] m;
        m = d;
        for (int b = 0; b < int'(NumBytes); b++) begin
            if (b >= int'(vlen)) m[b*8 +: 8] = 8'h00;
        end
        return m;
    endfunction

    // Decode always accepts; the unit reads rs1 only and clobbers the vector destination.
    assign io.dec_rsp_valid      = io.dec_req_valid;
    assign io.dec_req_ready      = io.dec_req_valid & io.dec_rsp_ready;
    assign io.dec_rsp_id         = io.dec_req_id;
    assign io.dec_rsp_accept     = 1'b1;
    assign io.dec_rsp_rs_read    = 2'b01;
    assign io.dec_rsp_vs_read    = 2'b00;
    assign io.dec_rsp_vd_clobber = 1'b1;
    assign io.dec_rsp_rd_clobber = 1'b0;

    assign rs0_c           = io.exe_req_rs0;
    assign base_addr_c     = AddrWidth'(rs0_c) & ~AddrWidth'(NumBytes - 1);
    assign vlen_raw_c      = io.exe_req_instr[25 +: VecLenWidth];
    assign vlen_c          = (int'(vlen_raw_c) > int'(NumBytes)) ? VecLenWidth'(NumBytes) : vlen_raw_c;
    assign exe_req_ready_c = io.exe_req_valid & ~sb_q[io.exe_req_id].req_done;
    assign unused_bits     = ^{io.exe_req_instr, rs0_c};

    assign io.exe_req_ready   = exe_req_ready_c;
    assign io.exe_rsp_valid   = rsp_valid_q;
    assign io.exe_rsp_id      = rsp_id_q;
    assign io.exe_rsp_vd_data = rsp_data_q;
    assign io.exe_rsp_err     = rsp_err_q;
    assign io.axi_ar_valid    = ar_valid_q;
    assign io.axi_ar_id       = ar_id_q;
    assign io.axi_ar_addr     = ar_addr_q;
    assign io.axi_r_ready     = r_ready_q;

    // Scoreboard update, applied in order: request, AR issue, R capture, response issue, clean.
    always_comb begin
        sb_d        = sb_q;
        ar_valid_d  = ar_valid_q & ~io.axi_ar_ready;
        ar_id_d     = ar_id_q;
        ar_addr_d   = ar_addr_q;
        rsp_valid_d = rsp_valid_q & ~io.exe_rsp_ready;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        ar_pick     = 1'b0;
        rsp_pick    = 1'b0;

        if (exe_req_ready_c) begin
            sb_d[io.exe_req_id].addr     = base_addr_c;
            sb_d[io.exe_req_id].vlen     = vlen_c;
            sb_d[io.exe_req_id].req_done = 1'b1;
        end

        if (!ar_valid_d) begin
            for (int i = 0; i < int'(SbLen); i++) begin
                if (!ar_pick && sb_d[i].req_done && !sb_d[i].ar_done) begin
                    ar_pick         = 1'b1;
                    ar_valid_d      = 1'b1;
                    ar_id_d         = IdWidth'(i);
                    ar_addr_d       = sb_d[i].addr;
                    sb_d[i].ar_done = 1'b1;
                end
            end
        end

        // Beats for an ID that never issued an AR are dropped.
        if (io.axi_r_valid && r_ready_q && sb_d[io.axi_r_id].ar_done) begin
            sb_d[io.axi_r_id].data   = mask_bytes(io.axi_r_data, sb_d[io.axi_r_id].vlen);
            sb_d[io.axi_r_id].err    = (io.axi_r_resp != 2'b00);
            sb_d[io.axi_r_id].r_done = 1'b1;
        end

        if (!rsp_valid_d) begin
            for (int i = 0; i < int'(SbLen); i++) begin
                if (!rsp_pick && sb_d[i].r_done && !sb_d[i].rsp_done) begin
                    rsp_pick         = 1'b1;
                    rsp_valid_d      = 1'b1;
                    rsp_id_d         = IdWidth'(i);
                    rsp_data_d       = sb_d[i].data;
                    rsp_err_d        = sb_d[i].err;
                    sb_d[i].rsp_done = 1'b1;
                end
            end
        end

        for (int i = 0; i < int'(SbLen); i++) begin
            if (sb_d[i].req_done && sb_d[i].ar_done && sb_d[i].r_done && sb_d[i].rsp_done) begin
                sb_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(SbLen); i++) sb_q[i] <= '0;
            ar_valid_q  <= 1'b0;
            ar_id_q     <= '0;
            ar_addr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            r_ready_q   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(SbLen); i++) sb_q[i] <= sb_d[i];
            ar_valid_q  <= ar_valid_d;
            ar_id_q     <= ar_id_d;
            ar_addr_q   <= ar_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            r_ready_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_xadac_vload.sv
// Directed bench for xadac_vload: single load, AR backpressure, out-of-order R, error
// response, response backpressure and mid-flight reset.
module tb_xadac_vload;
    logic clk = 1'b0;
    logic rstn;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    xadac_vload_if #(.SbLen(4), .AddrWidth(32), .VecDataWidth(128), .RegDataWidth(32)) io ();

    xadac_vload #(
        .SbLen(4), .AddrWidth(32), .VecDataWidth(128), .VecLenWidth(5), .RegDataWidth(32)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .io  (io)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exe_req(input logic [1:0] id, input logic [4:0] vlen, input logic [31:0] rs0,
                           input logic exp_ready);
        io.exe_req_valid = 1'b1;
        io.exe_req_id    = id;
        io.exe_req_instr = 32'(vlen) << 25;
        io.exe_req_rs0   = rs0;
        #1;
        check("exe_req_ready", io.exe_req_ready, exp_ready);
        tick();
        io.exe_req_valid = 1'b0;
    endtask

    task automatic r_beat(input logic [1:0] id, input logic [127:0] data, input logic [1:0] resp);
        io.axi_r_valid = 1'b1;
        io.axi_r_id    = id;
        io.axi_r_data  = data;
        io.axi_r_resp  = resp;
        tick();
        io.axi_r_valid = 1'b0;
    endtask

    task automatic check_ar(input string tag, input logic v, input logic [1:0] id, input logic [31:0] addr);
        check({tag, "_valid"}, io.axi_ar_valid, v);
        if (v) begin
            check({tag, "_id"}, io.axi_ar_id, id);
            check({tag, "_addr"}, io.axi_ar_addr, addr);
        end
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [1:0] id,
                             input logic [127:0] data, input logic err);
        check({tag, "_valid"}, io.exe_rsp_valid, v);
        if (v) begin
            check({tag, "_id"}, io.exe_rsp_id, id);
            check({tag, "_data"}, io.exe_rsp_vd_data, data);
            check({tag, "_err"}, io.exe_rsp_err, err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        io.dec_req_valid = 1'b0; io.dec_req_id = '0; io.dec_rsp_ready = 1'b0;
        io.exe_req_valid = 1'b0; io.exe_req_id = '0; io.exe_req_instr = '0; io.exe_req_rs0 = '0;
        io.exe_rsp_ready = 1'b0; io.axi_ar_ready = 1'b0;
        io.axi_r_valid = 1'b0; io.axi_r_id = '0; io.axi_r_data = '0; io.axi_r_resp = '0;

        // Reset state
        repeat (3) tick();
        check("rst_ar_valid", io.axi_ar_valid, 1'b0);
        check("rst_rsp_valid", io.exe_rsp_valid, 1'b0);
        check("rst_r_ready", io.axi_r_ready, 1'b0);
        rstn = 1'b1;
        tick();
        check("r_ready_after_rst", io.axi_r_ready, 1'b1);

        // Decode response fields
        io.dec_req_valid = 1'b1; io.dec_req_id = 2'd2; io.dec_rsp_ready = 1'b1;
        #1;
        check("dec_rsp_valid", io.dec_rsp_valid, 1'b1);
        check("dec_rsp_id", io.dec_rsp_id, 2'd2);
        check("dec_rsp_accept", io.dec_rsp_accept, 1'b1);
        check("dec_rsp_rs_read", io.dec_rsp_rs_read, 2'b01);
        check("dec_rsp_vs_read", io.dec_rsp_vs_read, 2'b00);
        check("dec_rsp_vd_clobber", io.dec_rsp_vd_clobber, 1'b1);
        check("dec_rsp_rd_clobber", io.dec_rsp_rd_clobber, 1'b0);
        check("dec_req_ready", io.dec_req_ready, 1'b1);
        io.dec_rsp_ready = 1'b0;
        #1;
        check("dec_req_ready_stall", io.dec_req_ready, 1'b0);
        io.dec_req_valid = 1'b0;
        #1;
        check("dec_rsp_valid_idle", io.dec_rsp_valid, 1'b0);

        // Single load, zero wait states
        io.axi_ar_ready = 1'b1; io.exe_rsp_ready = 1'b1;
        exe_req(2'd0, 5'd4, 32'h0000_1003, 1'b1);
        check_ar("t1_ar", 1'b1, 2'd0, 32'h1000);
        check("t1_rsp_early", io.exe_rsp_valid, 1'b0);
        tick();
        check_ar("t1_ar_done", 1'b0, 2'd0, 32'h0);
        r_beat(2'd0, {128{1'b1}}, 2'b00);
        check_rsp("t1_rsp", 1'b1, 2'd0, 128'hFFFF_FFFF, 1'b0);
        tick();
        check_rsp("t1_rsp_done", 1'b0, 2'd0, '0, 1'b0);

        // Four IDs with AR held off; fifth request stalls
        io.axi_ar_ready = 1'b0;
        exe_req(2'd0, 5'd31, 32'h0000_2005, 1'b1);
        check_ar("t2_ar0", 1'b1, 2'd0, 32'h2000);
        exe_req(2'd1, 5'd8, 32'h0000_2105, 1'b1);
        exe_req(2'd2, 5'd1, 32'h0000_2205, 1'b1);
        exe_req(2'd3, 5'd0, 32'h0000_2305, 1'b1);
        exe_req(2'd0, 5'd4, 32'h0000_9999, 1'b0);
        check_ar("t2_ar0_hold", 1'b1, 2'd0, 32'h2000);
        io.axi_ar_ready = 1'b1;
        tick(); check_ar("t2_ar1", 1'b1, 2'd1, 32'h2100);
        tick(); check_ar("t2_ar2", 1'b1, 2'd2, 32'h2200);
        tick(); check_ar("t2_ar3", 1'b1, 2'd3, 32'h2300);
        tick(); check_ar("t2_ar_idle", 1'b0, 2'd0, 32'h0);

        // R out of order 2,0,3,1; id1 returns SLVERR
        r_beat(2'd2, {16{8'hA2}}, 2'b00);
        check_rsp("t3_rsp2", 1'b1, 2'd2, 128'hA2, 1'b0);
        r_beat(2'd0, {16{8'hA0}}, 2'b00);
        check_rsp("t3_rsp0", 1'b1, 2'd0, {16{8'hA0}}, 1'b0);
        r_beat(2'd3, {16{8'hA3}}, 2'b00);
        check_rsp("t3_rsp3", 1'b1, 2'd3, 128'h0, 1'b0);
        r_beat(2'd1, {16{8'hA1}}, 2'b10);
        check_rsp("t4_rsp1", 1'b1, 2'd1, 128'hA1A1_A1A1_A1A1_A1A1, 1'b1);
        tick();
        check_rsp("t4_rsp_done", 1'b0, 2'd0, '0, 1'b0);
        exe_req(2'd1, 5'd2, 32'h0000_6000, 1'b1);
        check_ar("t4_ar1_reuse", 1'b1, 2'd1, 32'h6000);
        tick();
        r_beat(2'd1, {16{8'h5A}}, 2'b00);
        check_rsp("t4_rsp1_reuse", 1'b1, 2'd1, 128'h5A5A, 1'b0);
        tick();

        // R for an idle ID is ignored
        r_beat(2'd2, {128{1'b1}}, 2'b00);
        check("t4_ignored_r", io.exe_rsp_valid, 1'b0);
        tick();
        check("t4_ignored_r2", io.exe_rsp_valid, 1'b0);

        // Response backpressure with three completed loads
        io.exe_rsp_ready = 1'b0;
        exe_req(2'd3, 5'd2, 32'h0000_3000, 1'b1);
        check_ar("t5_ar3", 1'b1, 2'd3, 32'h3000);
        exe_req(2'd2, 5'd16, 32'h0000_3100, 1'b1);
        check_ar("t5_ar2", 1'b1, 2'd2, 32'h3100);
        exe_req(2'd1, 5'd3, 32'h0000_3200, 1'b1);
        check_ar("t5_ar1", 1'b1, 2'd1, 32'h3200);
        tick();
        r_beat(2'd3, {16{8'h33}}, 2'b00);
        check_rsp("t5_hold_a", 1'b1, 2'd3, 128'h3333, 1'b0);
        r_beat(2'd2, {16{8'h22}}, 2'b00);
        check_rsp("t5_hold_b", 1'b1, 2'd3, 128'h3333, 1'b0);
        r_beat(2'd1, {16{8'h11}}, 2'b00);
        for (int k = 0; k < 8; k++) begin
            check_rsp("t5_hold", 1'b1, 2'd3, 128'h3333, 1'b0);
            tick();
        end
        io.exe_rsp_ready = 1'b1;
        tick(); check_rsp("t5_rsp1", 1'b1, 2'd1, 128'h11_1111, 1'b0);
        tick(); check_rsp("t5_rsp2", 1'b1, 2'd2, {16{8'h22}}, 1'b0);
        tick(); check_rsp("t5_idle", 1'b0, 2'd0, '0, 1'b0);

        // Reset with three entries in flight
        io.axi_ar_ready = 1'b0;
        exe_req(2'd0, 5'd16, 32'h0000_7000, 1'b1);
        exe_req(2'd1, 5'd16, 32'h0000_7100, 1'b1);
        exe_req(2'd2, 5'd16, 32'h0000_7200, 1'b1);
        check_ar("t6_ar0", 1'b1, 2'd0, 32'h7000);
        rstn = 1'b0;
        #1;
        check("t6_rst_ar_valid", io.axi_ar_valid, 1'b0);
        check("t6_rst_rsp_valid", io.exe_rsp_valid, 1'b0);
        check("t6_rst_r_ready", io.axi_r_ready, 1'b0);
        tick();
        rstn = 1'b1;
        io.axi_ar_ready = 1'b1;
        tick();
        check("t6_r_ready", io.axi_r_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("t6_no_ar", io.axi_ar_valid, 1'b0);
            check("t6_no_rsp", io.exe_rsp_valid, 1'b0);
            tick();
        end
        exe_req(2'd0, 5'd16, 32'h0000_5000, 1'b1);
        check_ar("t6_ar0_new", 1'b1, 2'd0, 32'h5000);
        tick();
        r_beat(2'd0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 2'b00);
        check_rsp("t6_rsp0", 1'b1, 2'd0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
        tick();
        check_rsp("t6_idle", 1'b0, 2'd0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
